// File: rtl/fetch_stall_unit_if.sv
// IF-stage handshake bundle: stall/flush controls, instruction-memory port and IF/ID outputs.
// The fetch unit connects through the slave modport; the pipeline/memory side uses master.
interface fetch_stall_unit_if #(
    parameter int XLEN = 32
);
    logic            PC_Write;
    logic            IF_ID_Write;
    logic            Flush_D;
    logic [XLEN-1:0] Branch_Target;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic [XLEN-1:0] PC_D;
    logic [31:0]     Instr_D;
    logic            Valid_D;

    modport slave (
        input  PC_Write, IF_ID_Write, Flush_D, Branch_Target, imem_rdata,
        output imem_req, imem_addr, PC_D, Instr_D, Valid_D
    );

    modport master (
        output PC_Write, IF_ID_Write, Flush_D, Branch_Target, imem_rdata,
        input  imem_req, imem_addr, PC_D, Instr_D, Valid_D
    );
endinterface

// File: rtl/fetch_stall_unit.sv
// IF stage: owns PC_F, fetches from a 1-cycle imem, drives IF/ID with a 1-entry hold buffer.
// Optional macro FETCH_PERF_CNT_EN adds saturating stall_cnt/flush_cnt outputs.
module fetch_stall_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fetch_stall_unit_if.slave    bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          flush_cnt
`endif
);

    logic [XLEN-1:0] r_pc_f;
    logic            r_inflight;
    logic [XLEN-1:0] r_inflight_pc;
    logic            r_hold_valid;
    logic [XLEN-1:0] r_hold_pc;
    logic [31:0]     r_hold_instr;
    logic [XLEN-1:0] r_pc_d;
    logic [31:0]     r_instr_d;
    logic            r_valid_d;
    logic            w_req;
    logic            w_capture;

    // A pending hold entry only blocks fetch while it cannot drain this cycle, so a
    // stall release drains the hold and issues the next fetch together (no bubble).
    assign w_req = rst_n && bus.PC_Write && !bus.Flush_D
                 && !(r_hold_valid && !bus.IF_ID_Write)
                 && !(r_inflight && !bus.IF_ID_Write);

    assign w_capture = !bus.Flush_D && !bus.IF_ID_Write && r_inflight;

    assign bus.imem_req  = w_req;
    assign bus.imem_addr = r_pc_f;
    assign bus.PC_D      = r_pc_d;
    assign bus.Instr_D   = r_instr_d;
    assign bus.Valid_D   = r_valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_f       <= RESET_PC;
            r_inflight   <= 1'b0;
            r_hold_valid <= 1'b0;
            r_pc_d       <= '0;
            r_instr_d    <= NOP_INSTR;
            r_valid_d    <= 1'b0;
        end else if (bus.Flush_D) begin
            r_pc_f       <= bus.Branch_Target;
            r_inflight   <= 1'b0;
            r_hold_valid <= 1'b0;
            r_instr_d    <= NOP_INSTR;
            r_valid_d    <= 1'b0;
        end else begin
            r_inflight <= w_req;
            if (w_req) begin
                r_pc_f <= r_pc_f + XLEN'(4);
            end
            if (bus.IF_ID_Write) begin
                if (r_hold_valid) begin
                    r_pc_d       <= r_hold_pc;
                    r_instr_d    <= r_hold_instr;
                    r_valid_d    <= 1'b1;
                    r_hold_valid <= 1'b0;
                end else if (r_inflight) begin
                    r_pc_d    <= r_inflight_pc;
                    r_instr_d <= bus.imem_rdata;
                    r_valid_d <= 1'b1;
                end else begin
                    r_instr_d <= NOP_INSTR;
                    r_valid_d <= 1'b0;
                end
            end else if (r_inflight) begin
                r_hold_valid <= 1'b1;
            end
        end
    end

    // Payload registers are qualified by r_inflight / r_hold_valid and need no reset.
    always_ff @(posedge clk) begin
        if (w_req) begin
            r_inflight_pc <= r_pc_f;
        end
        if (w_capture) begin
            r_hold_pc    <= r_inflight_pc;
            r_hold_instr <= bus.imem_rdata;
        end
    end

    a_hold_no_overflow : assert property (
        @(posedge clk) disable iff (!rst_n) !(w_capture && r_hold_valid)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!bus.IF_ID_Write && !bus.Flush_D && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (bus.Flush_D && (r_flush_cnt != 32'hFFFF_FFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_fetch_stall_unit.sv
// Self-checking bench for fetch_stall_unit: IF/ID stream scoreboard plus per-cycle control checks.
module tb_fetch_stall_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    logic mon_wr, mon_fl, mon_rs;
    exp_t mon_e;

    fetch_stall_unit_if #(.XLEN(32)) bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
    fetch_stall_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus),
                          .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));
`else
    fetch_stall_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return 32'h0000_00A0 + (a >> 2);
    endfunction

    // Synchronous instruction memory, 1-cycle latency; garbage when not requested.
    always @(posedge clk) begin
        if (bus.imem_req) bus.imem_rdata <= instr_of(bus.imem_addr);
        else              bus.imem_rdata <= 32'hDEAD_BEEF;
    end

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] a);
        exp_t e;
        e.pc    = a;
        e.instr = instr_of(a);
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctl(input logic pcw, input logic ifw, input logic fl, input logic [31:0] tgt);
        bus.PC_Write      = pcw;
        bus.IF_ID_Write   = ifw;
        bus.Flush_D       = fl;
        bus.Branch_Target = tgt;
    endtask

    // Every IF/ID load of a real instruction must match the next expected entry, in order.
    always begin
        @(posedge clk);
        mon_wr = bus.IF_ID_Write;
        mon_fl = bus.Flush_D;
        mon_rs = rst_n;
        #1;
        if (mon_rs && rst_n && mon_wr && !mon_fl && bus.Valid_D) begin
            check_val("sb_avail", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check_val("sb_pc", bus.PC_D, mon_e.pc);
                check_val("sb_instr", bus.Instr_D, mon_e.instr);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        set_ctl(1'b1, 1'b1, 1'b0, 32'h0);
        repeat (2) tick();
        check_val("rst_req", bus.imem_req, 1'b0);
        check_val("rst_valid", bus.Valid_D, 1'b0);
        check_val("rst_instr", bus.Instr_D, NOP);
        check_val("rst_pcd", bus.PC_D, 32'h0);
        check_val("rst_addr", bus.imem_addr, 32'h0);

        for (int a = 0; a <= 32'h18; a += 4) push_exp(32'(a));
        rst_n = 1'b1;
        #1;
        check_val("c0_req", bus.imem_req, 1'b1);
        check_val("c0_addr", bus.imem_addr, 32'h0);
        tick();
        check_val("c0_valid", bus.Valid_D, 1'b0);
        tick();
        check_val("c1_valid", bus.Valid_D, 1'b1);
        check_val("c1_pcd", bus.PC_D, 32'h0);
        check_val("c1_instr", bus.Instr_D, 32'hA0);
        repeat (2) tick();
        check_val("c3_pcd", bus.PC_D, 32'h8);

        // single-cycle load-use stall at PC_F=0x10
        set_ctl(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        check_val("st1_req", bus.imem_req, 1'b0);
        tick();
        check_val("st1_pcd_hold", bus.PC_D, 32'h8);
        check_val("st1_addr", bus.imem_addr, 32'h10);
        set_ctl(1'b1, 1'b1, 1'b0, 32'h0);
        #1;
        check_val("rel1_req", bus.imem_req, 1'b1);
        check_val("rel1_addr", bus.imem_addr, 32'h10);
        tick();
        check_val("rel1_pcd", bus.PC_D, 32'hC);
        tick();
        check_val("rel1_next_pcd", bus.PC_D, 32'h10);
        check_val("rel1_no_bubble", bus.Valid_D, 1'b1);

        // three-cycle stall with PC_F=0x18
        set_ctl(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("st3_req", bus.imem_req, 1'b0);
            check_val("st3_addr", bus.imem_addr, 32'h18);
            tick();
        end
        check_val("st3_pcd_hold", bus.PC_D, 32'h10);
        set_ctl(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        check_val("rel3_pcd", bus.PC_D, 32'h14);
        tick();
        check_val("rel3_next_pcd", bus.PC_D, 32'h18);

        // flush on the second stall cycle, with the hold buffer occupied
        set_ctl(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        set_ctl(1'b0, 1'b0, 1'b1, 32'h100);
        #1;
        check_val("fl_req", bus.imem_req, 1'b0);
        tick();
        check_val("fl_valid", bus.Valid_D, 1'b0);
        check_val("fl_instr", bus.Instr_D, NOP);
        set_ctl(1'b1, 1'b1, 1'b0, 32'h0);
        push_exp(32'h100);
        push_exp(32'h104);
        #1;
        check_val("fl_tgt_req", bus.imem_req, 1'b1);
        check_val("fl_tgt_addr", bus.imem_addr, 32'h100);
        tick();
        check_val("fl_hold_cleared", bus.Valid_D, 1'b0);
        tick();
        check_val("fl_tgt_pcd", bus.PC_D, 32'h100);
        check_val("fl_tgt_instr", bus.Instr_D, 32'hE0);
        tick();
        check_val("fl_tgt_next_pcd", bus.PC_D, 32'h104);

        // async reset while the hold buffer is full
        set_ctl(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        check_val("mr_valid", bus.Valid_D, 1'b0);
        check_val("mr_instr", bus.Instr_D, NOP);
        check_val("mr_pcd", bus.PC_D, 32'h0);
        check_val("mr_req", bus.imem_req, 1'b0);
        check_val("mr_addr", bus.imem_addr, 32'h0);
        check_val("mr_sb_drained", 64'(exp_q.size()), 64'd0);
        tick();
        set_ctl(1'b1, 1'b1, 1'b0, 32'h0);
        push_exp(32'h0);
        push_exp(32'h4);
        push_exp(32'h8);
        rst_n = 1'b1;
        #1;
        check_val("rr_req", bus.imem_req, 1'b1);
        check_val("rr_addr", bus.imem_addr, 32'h0);
        tick();
        tick();
        check_val("rr_pcd", bus.PC_D, 32'h0);
        check_val("rr_instr", bus.Instr_D, 32'hA0);
        tick();
        set_ctl(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (3) tick();
        set_ctl(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        check_val("rr_rel_pcd", bus.PC_D, 32'h8);
        set_ctl(1'b1, 1'b1, 1'b1, 32'h200);
        tick();
        check_val("rr_fl_valid", bus.Valid_D, 1'b0);
`ifdef FETCH_PERF_CNT_EN
        check_val("stall_cnt", stall_cnt, 32'd3);
        check_val("flush_cnt", flush_cnt, 32'd1);
`endif
        set_ctl(1'b1, 1'b1, 1'b0, 32'h0);
        push_exp(32'h200);
        tick();
        check_val("tgt200_bubble", bus.Valid_D, 1'b0);
        tick();
        check_val("tgt200_pcd", bus.PC_D, 32'h200);

        // PC wrap past 2^32
        set_ctl(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        tick();
        set_ctl(1'b1, 1'b1, 1'b0, 32'h0);
        push_exp(32'hFFFF_FFFC);
        push_exp(32'h0);
        push_exp(32'h4);
        #1;
        check_val("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFC);
        tick();
        check_val("wrap_addr1", bus.imem_addr, 32'h0);
        check_val("wrap_req1", bus.imem_req, 1'b1);
        tick();
        check_val("wrap_pcd0", bus.PC_D, 32'hFFFF_FFFC);
        check_val("wrap_instr0", bus.Instr_D, 32'h4000_009F);
        tick();
        check_val("wrap_pcd1", bus.PC_D, 32'h0);
        set_ctl(1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        tick();
        check_val("end_bubble", bus.Valid_D, 1'b0);
        check_val("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
